// File: rtl/tank_display_pkg.sv
// Shared types and helpers for the tank level matrix display: ramp FSM states,
// level-to-height scaling and height classification.
package tank_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RISE,
    ST_FALL
  } ramp_state_e;

  // Scales a level code to a bar height. The product is formed at 64 bits so it
  // cannot overflow for any practical level width.
  function automatic int unsigned level_to_height(int unsigned level,
                                                  int unsigned rows,
                                                  int unsigned lmax);
    logic [63:0] prod;
    prod = 64'(level) * 64'(rows);
    return 32'(prod / 64'(lmax));
  endfunction

  function automatic ramp_state_e classify(int unsigned d, int unsigned h);
    if (d == h) return ST_IDLE;
    return (d < h) ? ST_RISE : ST_FALL;
  endfunction

endpackage

// File: rtl/tank_level_matrix_driver_if.sv
// Level input and matrix drive signals of the tank level display.
interface tank_level_matrix_driver_if #(
  parameter int ROWS    = 7,
  parameter int COLS    = 5,
  parameter int LEVEL_W = 2
);
  logic [LEVEL_W-1:0] tank_level;
  logic               level_valid;
  logic [COLS-1:0]    columns_n;
  logic [ROWS-1:0]    rows_n;
  logic               frame_tick;
  logic               settled;

  modport master (
    output tank_level, level_valid,
    input  columns_n, rows_n, frame_tick, settled
  );

  modport slave (
    input  tank_level, level_valid,
    output columns_n, rows_n, frame_tick, settled
  );
endinterface

// File: rtl/tank_scan_timer.sv
// Column scan timer: dwells SCAN_DIV clocks per column and pulses frame_tick
// in the first cycle of column 0 after a wrap.
module tank_scan_timer #(
  parameter int COLS     = 5,
  parameter int SCAN_DIV = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic [$clog2(COLS)-1:0] col_idx,
  output logic                    frame_tick
);
  localparam int TW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(COLS);
  localparam logic [TW-1:0] TIMER_LAST = TW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);

  logic [TW-1:0] timer;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer      <= '0;
      col_idx    <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (timer == TIMER_LAST) begin
        timer <= '0;
        if (col_idx == COL_LAST) begin
          col_idx    <= '0;
          frame_tick <= 1'b1;
        end else begin
          col_idx <= col_idx + 1'b1;
        end
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tank_level_matrix_driver.sv
// Tank level bar-graph driver: scans an LED matrix column by column, ramps the
// displayed height toward the sensor level and blinks an empty alarm.
module tank_level_matrix_driver
  import tank_display_pkg::*;
#(
  parameter int ROWS         = 7,
  parameter int COLS         = 5,
  parameter int LEVEL_W      = 2,
  parameter int SCAN_DIV     = 1000,
  parameter int STEP_FRAMES  = 8,
  parameter int BLINK_FRAMES = 25
) (
  input logic                       clk,
  input logic                       reset,
  tank_level_matrix_driver_if.slave bus
);
  localparam int LMAX = (1 << LEVEL_W) - 1;
  localparam int CW   = $clog2(COLS);
  localparam int HW   = $clog2(ROWS + 1);
  localparam int SW   = $clog2(STEP_FRAMES + 1);
  localparam int BW   = $clog2(BLINK_FRAMES + 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
  localparam logic [HW-1:0] FULL_H     = HW'(ROWS);
  localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_FRAMES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [CW-1:0]   col_idx;
  logic            frame_tick;
  ramp_state_e     state;
  logic [HW-1:0]   h, d, h_next, d_next;
  logic [SW-1:0]   step_cnt, step_cnt_next;
  logic [BW-1:0]   blink_cnt;
  logic            blink_on;
  logic            alarm;
  logic [ROWS-1:0] row_lit;
  logic [COLS-1:0] columns_n_q;
  logic [ROWS-1:0] rows_n_q;
  logic            settled_q;

  tank_scan_timer #(
    .COLS     (COLS),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk        (clk),
    .reset      (reset),
    .col_idx    (col_idx),
    .frame_tick (frame_tick)
  );

  assign alarm = (d == '0) && (h == '0);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    d_next        = d;
    h_next        = h;
    step_cnt_next = step_cnt;
    // The step compares against the target held before this edge; a coincident
    // level_valid only takes effect afterwards.
    if (frame_tick && (d != h)) begin
      if (step_cnt == STEP_LAST) begin
        step_cnt_next = '0;
        if ((d < h) && (d != FULL_H))   d_next = d + 1'b1;
        else if ((d > h) && (d != '0))  d_next = d - 1'b1;
      end else begin
        step_cnt_next = step_cnt + 1'b1;
      end
    end
    if (bus.level_valid) h_next = HW'(level_to_height(32'(bus.tank_level), ROWS, LMAX));
    if (d_next == h_next) step_cnt_next = '0;
  end

  always_comb begin
    row_lit = ~({ROWS{1'b1}} >> d);
    if ((col_idx == '0) || (col_idx == COL_LAST)) row_lit = '1;
    else if (alarm && blink_on)                   row_lit[ROWS-1] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      d           <= '0;
      h           <= '0;
      step_cnt    <= '0;
      blink_cnt   <= '0;
      blink_on    <= 1'b1;
      columns_n_q <= '1;
      rows_n_q    <= '1;
      settled_q   <= 1'b1;
    end else begin
      state    <= classify(32'(d_next), 32'(h_next));
      d        <= d_next;
      h        <= h_next;
      step_cnt <= step_cnt_next;
      if (!alarm) begin
        blink_cnt <= '0;
        blink_on  <= 1'b1;
      end else if (frame_tick) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
      columns_n_q <= ~(COLS'(1) << col_idx);
      rows_n_q    <= ~row_lit;
      settled_q   <= (state == ST_IDLE);
    end
  end

  assign bus.columns_n  = columns_n_q;
  assign bus.rows_n     = rows_n_q;
  assign bus.frame_tick = frame_tick;
  assign bus.settled    = settled_q;

endmodule

// File: doc/tank_level_matrix_driver.md
TANK_LEVEL_MATRIX_DRIVER -- requirements
Module: tank_level_matrix_driver

Interface
REQ-001 Parameter ROWS, default 7, matrix rows; row ROWS-1 is the bottom row.
REQ-002 Parameter COLS, default 5, matrix columns, minimum 3.
REQ-003 Parameter LEVEL_W, default 2, level input width; LMAX = 2^LEVEL_W-1.
REQ-004 Parameter SCAN_DIV, default 1000, clocks per column dwell, minimum 2.
REQ-005 Parameter STEP_FRAMES, default 8, frames per one-row ramp step, minimum 1.
REQ-006 Parameter BLINK_FRAMES, default 25, frames per empty-alarm blink half-period, minimum 1.
REQ-007 clk  in  1  single clock; all state changes on rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 tank_level  in  LEVEL_W  sensor level code, 0 = empty, LMAX = full.
REQ-010 level_valid  in  1  one-cycle strobe; tank_level is sampled only when high.
REQ-011 columns_n  out  COLS  active-low one-hot column select.
REQ-012 rows_n  out  ROWS  active-low row drive for the selected column.
REQ-013 frame_tick  out  1  one-cycle pulse when scan wraps from column COLS-1 to 0.
REQ-014 settled  out  1  high when displayed height equals target height.

Function
REQ-015 Scan timer SHALL count 0..SCAN_DIV-1; at SCAN_DIV-1 it wraps and the column index advances by 1, wrapping COLS-1 -> 0.
REQ-016 frame_tick SHALL assert in exactly the cycle the column index wraps to 0.
REQ-017 On level_valid, target height H SHALL load floor(tank_level*ROWS/LMAX), computed at full width without overflow; H is held otherwise.
REQ-018 Displayed height D SHALL change only on frame_tick, once every STEP_FRAMES frames, by exactly +1 or -1 toward H.
REQ-019 FSM states: IDLE (D==H), RISE (D<H), FALL (D>H); state re-evaluated every cycle from D and H; a target change mid-ramp reverses direction at the next step.
REQ-020 Step-frame counter SHALL reset to 0 whenever the FSM enters IDLE, so the first step after a new target occurs STEP_FRAMES frames later.
REQ-021 level_valid coincident with a step frame_tick: the step SHALL use the old H; the new H applies from the next cycle.
REQ-022 Columns 0 and COLS-1 (walls) SHALL light all rows always.
REQ-023 Interior columns SHALL light rows ROWS-D .. ROWS-1 (bottom D rows); D=0 lights none, D=ROWS lights all.
REQ-024 Empty alarm: when D==0 and H==0, interior columns SHALL light row ROWS-1 during blink phase ON; phase toggles every BLINK_FRAMES frames, starting ON on alarm entry.
REQ-025 columns_n and rows_n SHALL be registered: one clock latency from column index/D/blink change.
REQ-026 settled SHALL equal (state==IDLE), registered with the same latency.
REQ-027 D SHALL saturate in 0..ROWS; no wrap-around.

Reset
REQ-028 While reset high: columns_n and rows_n all ones, frame_tick 0, settled 1.
REQ-029 Reset SHALL clear scan timer, column index, step and blink counters to 0, H and D to 0, FSM to IDLE, blink phase ON.
REQ-030 Reset mid-ramp SHALL abandon the ramp; first output after release selects column 0.

Structure
REQ-031 Package tank_display_pkg SHALL hold the FSM state enum and the level-to-height function.
REQ-032 Scan timer with column index and frame_tick SHALL be sub-module tank_scan_timer.

Verification (ROWS=7, COLS=5, LEVEL_W=2, SCAN_DIV=4, STEP_FRAMES=2, BLINK_FRAMES=3)
REQ-033 Release reset, hold 60 cycles -> columns_n cycles 11110,11101,11011,10111,01111 each 4 clocks; frame_tick every 20 clocks.
REQ-034 level_valid with level 3 -> settled drops, D rises 0->7 one row per 40 clocks; interior rows_n reaches 0000000, settled returns high.
REQ-035 From D=7, level 1 -> H=2; D falls to 2; interior rows_n = 0011111; walls remain 0000000.
REQ-036 Level 2 (H=4) then level 0 while D=2 ramping up -> D reverses to 0 without exceeding 3.
REQ-037 Idle empty -> interior rows_n toggles between 0111111 and 1111111 every 60 clocks.
REQ-038 Assert reset at D=5 mid-ramp -> outputs all ones during reset; after release D=0, column 0 selected, settled 1.
